data_memory_ctrl: RTL and testbench

//   Parametrised data memory for the MIPS datapath with a request/response handshake.

---
 rtl/data_memory_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Data memory for the MIPS datapath behind a request/response handshake.
//   Handles LB/LBU/LH/LHU/LW/SB/SH/SW on byte addresses, flags misaligned,
//   illegal-size and out-of-range accesses, and can insert a fixed number of
//   wait states between accepting a request and presenting its response.
//
// Parameters
//   ADDR_W       byte-address width of req_addr
//   DEPTH_WORDS  number of 32-bit words in the array
//   WAIT_CYCLES  extra cycles between accept and response (0..255)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset (array contents survive)
//   req_valid     request present
//   req_ready     high only in IDLE while rst is low
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    registered response strobe, held until taken
//   resp_ready    consumer takes the response
//   resp_rdata    extended load data; 0 for stores and errors
//   resp_err      misaligned, illegal size, or out of range
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Counter value on which the last wait cycle is spent.
    localparam logic [7:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [7:0]         wait_cnt_reg;
    logic               lat_we_reg;
    logic [1:0]         lat_size_reg;
    logic               lat_unsigned_reg;
    logic [ADDR_W-1:0]  lat_addr_reg;
    logic [31:0]        lat_wdata_reg;

    logic [31:0]        mem [DEPTH_WORDS];

    // Operation currently being resolved: live inputs on the accept edge
    // (needed when there are no wait states), latched copy afterwards.
    logic               op_we;
    logic [1:0]         op_size;
    logic               op_unsigned;
    logic [ADDR_W-1:0]  op_addr;
    logic [31:0]        op_wdata;

    logic [ADDR_W-3:0]  word_idx;
    logic [1:0]         lane;
    logic [IDX_W-1:0]   mem_idx;
    logic               out_of_range;
    logic               op_err;
    logic [3:0]         op_be;
    logic [31:0]        op_wlane;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_val;
    logic [31:0]        resp_data;
    logic               accept;
    logic               enter_resp;
    logic               commit;

    assign req_ready = (state_reg == S_IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    always_comb begin
        op_we       = lat_we_reg;
        op_size     = lat_size_reg;
        op_unsigned = lat_unsigned_reg;
        op_addr     = lat_addr_reg;
        op_wdata    = lat_wdata_reg;
        if (state_reg == S_IDLE) begin
            op_we       = req_we;
            op_size     = req_size;
            op_unsigned = req_unsigned;
            op_addr     = req_addr;
            op_wdata    = req_wdata;
        end
    end

    assign word_idx     = op_addr[ADDR_W-1:2];
    assign lane         = op_addr[1:0];
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign out_of_range = (64'(word_idx) >= 64'(DEPTH_WORDS));

    always_comb begin
        op_err = 1'b0;
        case (op_size)
            2'b00:   op_err = 1'b0;
            2'b01:   op_err = lane[0];
            2'b10:   op_err = (lane != 2'b00);
            default: op_err = 1'b1;
        endcase
        op_err = op_err | out_of_range;
    end

    // Store data is replicated across lanes so the byte enables alone pick
    // which bytes land in the word.
    always_comb begin
        op_be    = 4'b1111;
        op_wlane = op_wdata;
        case (op_size)
            2'b00: begin
                op_be    = 4'b0001 << lane;
                op_wlane = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                op_be    = lane[1] ? 4'b1100 : 4'b0011;
                op_wlane = {2{op_wdata[15:0]}};
            end
            default: begin
                op_be    = 4'b1111;
                op_wlane = op_wdata;
            end
        endcase
    end

    assign rd_word = mem[mem_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (op_size)
            2'b00:   load_val = op_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = op_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    assign resp_data = (op_we | op_err) ? 32'd0 : load_val;

    // The access resolves on the edge that moves the FSM into RESP.
    assign enter_resp = ~rst &
                        (((state_reg == S_IDLE) & accept & (WAIT_CYCLES == 0)) |
                         ((state_reg == S_WAIT) & (wait_cnt_reg == LAST_WAIT)));
    assign commit     = enter_resp & op_we & ~op_err;

    // Array has no reset: contents persist across rst.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= op_wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            wait_cnt_reg     <= 8'd0;
            lat_we_reg       <= 1'b0;
            lat_size_reg     <= 2'b00;
            lat_unsigned_reg <= 1'b0;
            lat_addr_reg     <= '0;
            lat_wdata_reg    <= 32'd0;
            resp_valid       <= 1'b0;
            resp_rdata       <= 32'd0;
            resp_err         <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        lat_we_reg       <= req_we;
                        lat_size_reg     <= req_size;
                        lat_unsigned_reg <= req_unsigned;
                        lat_addr_reg     <= req_addr;
                        lat_wdata_reg    <= req_wdata;
                        wait_cnt_reg     <= 8'd0;
                        state_reg        <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == LAST_WAIT) begin
                        wait_cnt_reg <= 8'd0;
                        state_reg    <= S_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_reg  <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_rdata <= resp_data;
                resp_err   <= op_err;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Two instances: one with no wait states, one with three. A byte-addressed
//   little-endian reference memory per instance predicts load data and errors.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata [2];
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    int passed = 0;
    int total  = 0;
    int wc [2] = '{0, 3};

    logic [7:0] mref [2][DEPTH*4];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_memory_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    // Reference: bytes at consecutive addresses, little-endian.
    task automatic model_access(input int s, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic e);
        int nbytes;
        logic [31:0] v;
        e = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
        rd = 32'd0;
        if (!e) begin
            nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            if (we) begin
                for (int i = 0; i < nbytes; i++) mref[s][int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nbytes; i++) v = v | (32'(mref[s][int'(addr) + i]) << (8*i));
                if (nbytes < 4 && !uns && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
                rd = v;
            end
        end
    endtask

    // Full transaction: present, accept, wait for response, take it.
    task automatic do_access(input int s, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output logic [31:0] exp_rdata, output logic exp_err);
        @(posedge clk); #1;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid[s] = 1'b1;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        // Request fields must not matter after acceptance.
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (resp_valid[s] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata[s];
        err   = resp_err[s];
        resp_ready[s] = 1'b1;
        @(posedge clk); #1;
        resp_ready[s] = 1'b0;
        model_access(s, we, size, uns, addr, wdata, exp_rdata, exp_err);
        $display("txn dut%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 s, we, size, uns, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total++; if (req_ready[s] !== 1'b0) $display("FAIL reset_ready_low dut%0d: got %b expected 0", s, req_ready[s]); else passed++;
        end
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            total++; if (req_ready[s] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b expected 1", s, req_ready[s]); else passed++;
            total++; if (resp_valid[s] !== 1'b0) $display("FAIL reset_resp_valid dut%0d: got %b expected 0", s, resp_valid[s]); else passed++;
            total++; if (resp_rdata[s] !== 32'd0) $display("FAIL reset_rdata dut%0d: got %h expected 0", s, resp_rdata[s]); else passed++;
            total++; if (resp_err[s] !== 1'b0) $display("FAIL reset_err dut%0d: got %b expected 0", s, resp_err[s]); else passed++;
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic e, ee; int lat;
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat, erd, ee);
        total++; if (lat !== 1) $display("FAIL sw_latency: got %0d expected 1", lat); else passed++;
        total++; if (rd !== 32'd0 || e !== 1'b0) $display("FAIL sw_resp: got rdata=%h err=%b expected 0/0", rd, e); else passed++;
        total++; if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0) $display("FAIL resp_clear: got valid=%b rdata=%h expected 0/0", resp_valid[0], resp_rdata[0]); else passed++;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, e, lat, erd, ee);
        total++; if (lat !== 1) $display("FAIL lw_latency: got %0d expected 1", lat); else passed++;
        total++; if (rd !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL lw_data: got %h err=%b expected deadbeef err=0", rd, e); else passed++;
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd; logic e, ee; int lat;
        do_access(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h80, rd, e, lat, erd, ee);
        do_access(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_sign: got %h expected ffffff80", rd); else passed++;
        do_access(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'h00000080) $display("FAIL lbu_zero: got %h expected 00000080", rd); else passed++;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'hDEAD80EF) $display("FAIL sb_merge: got %h expected dead80ef", rd); else passed++;
    endtask

    task automatic test_half();
        logic [31:0] rd, erd; logic e, ee; int lat;
        do_access(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, rd, e, lat, erd, ee);
        do_access(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'h00001234 || e !== 1'b0) $display("FAIL lh_data: got %h err=%b expected 00001234 err=0", rd, e); else passed++;
        do_access(0, 1'b0, 2'd1, 1'b0, 32'h13, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'd0 || e !== 1'b1) $display("FAIL lh_misaligned: got %h err=%b expected 0 err=1", rd, e); else passed++;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'h123480EF) $display("FAIL sh_merge: got %h expected 123480ef", rd); else passed++;
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFEF00D, rd, e, lat, erd, ee);
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h02, 32'h99999999, rd, e, lat, erd, ee);
        total++; if (e !== 1'b1) $display("FAIL sw_misaligned_err: got %b expected 1", e); else passed++;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h00, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'hCAFEF00D) $display("FAIL sw_misaligned_nowrite: got %h expected cafef00d", rd); else passed++;
    endtask

    task automatic test_wait_hold();
        logic [31:0] rd, erd, held; logic e, ee; int lat, cyc, ready_bad, stable_bad;
        do_access(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A55A5A, rd, e, lat, erd, ee);
        total++; if (lat !== 4) $display("FAIL wait_sw_latency: got %0d expected 4", lat); else passed++;
        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'd0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_addr = 32'h10;
        cyc = 1; ready_bad = 0;
        while (resp_valid[1] !== 1'b1 && cyc < 64) begin
            if (req_ready[1] !== 1'b0) ready_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (cyc !== 4) $display("FAIL wait_resp_cycle: got %0d expected 4", cyc); else passed++;
        total++; if (ready_bad !== 0) $display("FAIL wait_ready_low: got %0d high samples expected 0", ready_bad); else passed++;
        held = resp_rdata[1];
        total++; if (held !== 32'hA5A55A5A) $display("FAIL wait_lw_data: got %h expected a5a55a5a", held); else passed++;
        stable_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== held || req_ready[1] !== 1'b0) stable_bad++;
        end
        total++; if (stable_bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles expected 0", stable_bad); else passed++;
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        total++; if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", resp_valid[1], req_ready[1]); else passed++;
    endtask

    task automatic test_range();
        logic [31:0] rd, erd; logic e, ee; int lat;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'(DEPTH * 4), 32'd0, rd, e, lat, erd, ee);
        total++; if (e !== 1'b1 || rd !== 32'd0) $display("FAIL lw_out_of_range: got err=%b rdata=%h expected 1/0", e, rd); else passed++;
        do_access(0, 1'b1, 2'd2, 1'b0, 32'(DEPTH * 4 - 4), 32'h0BADF00D, rd, e, lat, erd, ee);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'(DEPTH * 4 - 4), 32'd0, rd, e, lat, erd, ee);
        total++; if (e !== 1'b0 || rd !== 32'h0BADF00D) $display("FAIL lw_last_word: got err=%b rdata=%h expected 0/0badf00d", e, rd); else passed++;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'd0, rd, e, lat, erd, ee);
        total++; if (e !== 1'b1) $display("FAIL lw_high_addr: got err=%b expected 1", e); else passed++;
        do_access(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'd0, rd, e, lat, erd, ee);
        total++; if (e !== 1'b1 || rd !== 32'd0) $display("FAIL size11_dut0: got err=%b rdata=%h expected 1/0", e, rd); else passed++;
        do_access(1, 1'b1, 2'd3, 1'b0, 32'h44, 32'd7, rd, e, lat, erd, ee);
        total++; if (e !== 1'b1) $display("FAIL size11_dut1: got err=%b expected 1", e); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic e, ee; int lat, cyc, stray;
        do_access(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, rd, e, lat, erd, ee);
        // Reset while the store waits: it must be discarded.
        @(posedge clk); #1;
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h55;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) $display("FAIL rst_wait_outputs: got valid=%b ready=%b expected 0/0", resp_valid[1], req_ready[1]); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (req_ready[1] !== 1'b1) $display("FAIL rst_wait_idle: got ready=%b expected 1", req_ready[1]); else passed++;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (resp_valid[1] !== 1'b0) stray++;
        end
        total++; if (stray !== 0) $display("FAIL rst_wait_dropped: got %0d valid cycles expected 0", stray); else passed++;
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'h11111111) $display("FAIL rst_wait_discard: got %h expected 11111111", rd); else passed++;
        // Reset while the response is pending: the store already happened.
        @(posedge clk); #1;
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h24; req_wdata = 32'h22;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        cyc = 1;
        while (resp_valid[1] !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (cyc !== 4) $display("FAIL rst_resp_reach: got %0d expected 4", cyc); else passed++;
        rst = 1'b1;
        #1;
        total++; if (resp_valid[1] !== 1'b0) $display("FAIL rst_resp_clear: got valid=%b expected 0", resp_valid[1]); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_access(1, 1'b1, 2'd2, 1'b0, 32'h24, 32'h22, erd, ee);
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0, rd, e, lat, erd, ee);
        total++; if (rd !== 32'h22) $display("FAIL rst_resp_kept: got %h expected 00000022", rd); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr; logic e, ee, we, uns; logic [1:0] size; int lat, r;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 20; w++) begin
                addr = (w < 16) ? 32'(w * 4) : 32'((DEPTH - 20 + w) * 4);
                do_access(s, 1'b1, 2'd2, 1'b0, addr, $urandom, rd, e, lat, erd, ee);
            end
            for (int n = 0; n < 60; n++) begin
                r = int'($urandom_range(0, 7));
                if (r < 6)       addr = $urandom_range(0, 63);
                else if (r == 6) addr = 32'(DEPTH * 4 - 16) + $urandom_range(0, 15);
                else             addr = 32'(DEPTH * 4) + $urandom_range(0, 1000);
                r = int'($urandom_range(0, 7));
                size = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
                we  = 1'($urandom);
                uns = 1'($urandom);
                do_access(s, we, size, uns, addr, $urandom, rd, e, lat, erd, ee);
                total++; if (rd !== erd) $display("FAIL rand_rdata dut%0d #%0d: got %h expected %h", s, n, rd, erd); else passed++;
                total++; if (e !== ee) $display("FAIL rand_err dut%0d #%0d: got %b expected %b", s, n, e, ee); else passed++;
                total++; if (lat !== wc[s] + 1) $display("FAIL rand_latency dut%0d #%0d: got %0d expected %0d", s, n, lat, wc[s] + 1); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] erd; logic ee; int nresp, bad;
        for (int s = 0; s < 2; s++) begin
            model_access(s, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, erd, ee);
            @(posedge clk); #1;
            req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
            req_valid[s] = 1'b1; resp_ready[s] = 1'b1;
            nresp = 0; bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (resp_valid[s] === 1'b1) begin
                    nresp++;
                    if (resp_rdata[s] !== erd || resp_err[s] !== 1'b0) bad++;
                end
            end
            req_valid[s] = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            resp_ready[s] = 1'b0;
            $display("txn dut%0d streaming LW @10: %0d responses in 20 cycles", s, nresp);
            total++; if (nresp !== 20 / (wc[s] + 2)) $display("FAIL b2b_rate dut%0d: got %0d expected %0d", s, nresp, 20 / (wc[s] + 2)); else passed++;
            total++; if (bad !== 0) $display("FAIL b2b_data dut%0d: got %0d bad responses expected 0", s, bad); else passed++;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH * 4; i++) mref[s][i] = 8'd0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wait_hold();
        test_range();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
